// File: rtl/fm_demod_pkg.sv
`default_nettype none
// ============================================================
// fm_demod_pkg : shared constants, state encoding, Q10 helpers
// Rev 1.0
// ============================================================
package fm_demod_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int PROD_WIDTH         = 2 * DEFAULT_DATA_WIDTH;
   localparam int QUANT_BITS         = 10;
   localparam int QUAD1              = 804;
   localparam int QUAD3              = 3 * QUAD1;
   localparam int GAIN               = 758;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MULT      = 3'd1,
      DIV_START = 3'd2,
      DIV_WAIT  = 3'd3,
      ANGLE     = 3'd4,
      WRITE     = 3'd5
   } state_t;

   // Arithmetic shift floors; biasing negatives first makes it truncate toward zero.
   function automatic logic signed [PROD_WIDTH-1:0] dequant(input logic signed [PROD_WIDTH-1:0] x);
      logic signed [PROD_WIDTH-1:0] bias;
      bias = x[PROD_WIDTH-1] ? PROD_WIDTH'((1 << QUANT_BITS) - 1) : '0;
      return (x + bias) >>> QUANT_BITS;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fm_demod_if.sv
`default_nettype none
// ============================================================
// fm_demod_if : FIFO-side handshake bundle of the FM demodulator
// Rev 1.0
// ============================================================
interface fm_demod_if
   import fm_demod_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
   logic signed [DATA_WIDTH-1:0] Iin;
   logic signed [DATA_WIDTH-1:0] Qin;
   logic                         in_empty;
   logic                         in_rd_en;
   logic                         out_full;
   logic                         out_wr_en;
   logic signed [DATA_WIDTH-1:0] demod_out;

   modport master (
      output Iin, Qin, in_empty, out_full,
      input  in_rd_en, out_wr_en, demod_out
   );

   modport slave (
      input  Iin, Qin, in_empty, out_full,
      output in_rd_en, out_wr_en, demod_out
   );
endinterface
`default_nettype wire

// File: rtl/fm_demod_div_seq.sv
`default_nettype none
// ============================================================
// div_seq : radix-2 signed restoring divider, DATA_WIDTH cycles
// Rev 1.0
// ============================================================
module div_seq
   import fm_demod_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] dividend,
   input  logic signed [DATA_WIDTH-1:0] divisor,
   output logic signed [DATA_WIDTH-1:0] quotient,
   output logic                         done
);
   localparam int            CW   = $clog2(DATA_WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   logic                  r_busy;
   logic                  r_neg;
   logic [CW-1:0]         r_cnt;
   logic [DATA_WIDTH-1:0] r_rem;
   logic [DATA_WIDTH-1:0] r_quo;
   logic [DATA_WIDTH-1:0] r_dvs;

   logic [DATA_WIDTH-1:0] w_mag_a;
   logic [DATA_WIDTH-1:0] w_mag_b;
   logic [DATA_WIDTH:0]   w_shift;
   logic                  w_fit;
   logic [DATA_WIDTH-1:0] w_sub;
   logic [DATA_WIDTH-1:0] w_rem_next;
   logic [DATA_WIDTH-1:0] w_quo_next;

   assign w_mag_a = dividend[DATA_WIDTH-1] ? -dividend : dividend;
   assign w_mag_b = divisor[DATA_WIDTH-1]  ? -divisor  : divisor;

   // Remainder stays below the divisor, so the low DATA_WIDTH bits of the difference are exact.
   assign w_shift    = {r_rem, r_quo[DATA_WIDTH-1]};
   assign w_fit      = w_shift >= {1'b0, r_dvs};
   assign w_sub      = w_shift[DATA_WIDTH-1:0] - r_dvs;
   assign w_rem_next = w_fit ? w_sub : w_shift[DATA_WIDTH-1:0];
   assign w_quo_next = {r_quo[DATA_WIDTH-2:0], w_fit};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_busy   <= 1'b0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         quotient <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_neg  <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
            r_rem  <= '0;
            r_quo  <= w_mag_a;
            r_dvs  <= w_mag_b;
         end else if (r_busy) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
               r_busy   <= 1'b0;
               done     <= 1'b1;
               quotient <= r_neg ? -w_quo_next : w_quo_next;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/fm_demod.sv
`default_nettype none
// ============================================================
// fm_demod : FM discriminator, conjugate product + quadrant arctan
// Rev 1.0
// ============================================================
module fm_demod
   import fm_demod_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic      clock,
   input  logic      reset,
   fm_demod_if.slave bus
);
   localparam int                           PW  = PROD_WIDTH;
   localparam logic signed [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   state_t r_state;
   state_t w_next;

   logic signed [DATA_WIDTH-1:0] r_icur, r_qcur, r_iprev, r_qprev;
   logic signed [DATA_WIDTH-1:0] r_r, r_abs_y, r_q, r_result;
   logic                         r_i_neg;

   logic signed [DATA_WIDTH-1:0] w_r, w_i, w_abs_y, w_num, w_den, w_quot;
   logic signed [DATA_WIDTH-1:0] w_base, w_angle_raw, w_angle, w_result;
   logic                         w_div_start;
   logic                         w_div_done;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (!bus.in_empty) w_next = MULT;
         MULT:      w_next = DIV_START;
         DIV_START: w_next = DIV_WAIT;
         DIV_WAIT:  if (w_div_done) w_next = ANGLE;
         ANGLE:     w_next = WRITE;
         WRITE:     if (!bus.out_full) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_comb begin
      bus.in_rd_en  = 1'b0;
      bus.out_wr_en = 1'b0;
      w_div_start   = 1'b0;
      case (r_state)
         IDLE:      bus.in_rd_en  = !bus.in_empty;
         DIV_START: w_div_start   = 1'b1;
         WRITE:     bus.out_wr_en = !bus.out_full;
         default:   ;
      endcase
   end

   // Conjugate product cur * conj(prev), each partial product rescaled from Q20 to Q10.
   assign w_r = DATA_WIDTH'(dequant(PW'(r_icur) * PW'(r_iprev)) + dequant(PW'(r_qcur) * PW'(r_qprev)));
   assign w_i = DATA_WIDTH'(dequant(PW'(r_qcur) * PW'(r_iprev)) - dequant(PW'(r_icur) * PW'(r_qprev)));
   assign w_abs_y = (w_i[DATA_WIDTH-1] ? -w_i : w_i) + ONE;

   assign w_num = r_r[DATA_WIDTH-1] ? (r_r + r_abs_y) <<< QUANT_BITS : (r_r - r_abs_y) <<< QUANT_BITS;
   assign w_den = r_r[DATA_WIDTH-1] ? r_abs_y - r_r : r_r + r_abs_y;

   assign w_base      = r_r[DATA_WIDTH-1] ? DATA_WIDTH'(QUAD3) : DATA_WIDTH'(QUAD1);
   assign w_angle_raw = w_base - DATA_WIDTH'(dequant(PW'(r_q) * PW'(QUAD1)));
   assign w_angle     = r_i_neg ? -w_angle_raw : w_angle_raw;
   assign w_result    = DATA_WIDTH'(dequant(PW'(w_angle) * PW'(GAIN)));

   div_seq #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_div (
      .clock    (clock),
      .reset    (reset),
      .start    (w_div_start),
      .dividend (w_num),
      .divisor  (w_den),
      .quotient (w_quot),
      .done     (w_div_done)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_icur   <= '0;
         r_qcur   <= '0;
         r_iprev  <= '0;
         r_qprev  <= '0;
         r_r      <= '0;
         r_abs_y  <= '0;
         r_i_neg  <= 1'b0;
         r_q      <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            IDLE: if (!bus.in_empty) begin
               r_icur <= bus.Iin;
               r_qcur <= bus.Qin;
            end
            MULT: begin
               r_r     <= w_r;
               r_abs_y <= w_abs_y;
               r_i_neg <= w_i[DATA_WIDTH-1];
            end
            DIV_WAIT: if (w_div_done) r_q <= w_quot;
            ANGLE:    r_result <= w_result;
            WRITE: if (!bus.out_full) begin
               r_iprev <= r_icur;
               r_qprev <= r_qcur;
            end
            default: ;
         endcase
      end
   end

   assign bus.demod_out = r_result;
endmodule
`default_nettype wire

// File: tb/tb_fm_demod.sv
`default_nettype none
// ============================================================
// tb_fm_demod : FM demodulator bench with behavioural reference model
// Rev 1.0
// ============================================================
module tb_fm_demod;
   localparam int DW  = 32;
   localparam int LAT = DW + 5;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   fm_demod_if #(.DATA_WIDTH(DW)) bus ();

   fm_demod #(.DATA_WIDTH(DW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int cycle = 0;
   int pop_count = 0;
   int push_count = 0;
   int last_push = 0;
   int m_iprev = 0;
   int m_qprev = 0;

   typedef struct {
      int value;
      int pop_cycle;
      bit stalled;
   } exp_t;
   exp_t expq[$];

   function automatic longint dq(longint x);
      return x / 1024;
   endfunction

   function automatic longint wrap32(longint x);
      return longint'(int'(x));
   endfunction

   // Phase difference via quadrant arctan, straight from the arithmetic definition.
   function automatic int model(int ic, int qc, int ip, int qp);
      longint r, i, ay, num, den, q, ang;
      r  = wrap32(dq(longint'(ic) * ip) + dq(longint'(qc) * qp));
      i  = wrap32(dq(longint'(qc) * ip) - dq(longint'(ic) * qp));
      ay = wrap32(((i < 0) ? -i : i) + 1);
      if (r >= 0) begin
         num = wrap32((r - ay) * 1024);
         den = wrap32(r + ay);
      end else begin
         num = wrap32((r + ay) * 1024);
         den = wrap32(ay - r);
      end
      q   = wrap32(num / den);
      ang = wrap32(((r >= 0) ? 804 : 2412) - dq(804 * q));
      if (i < 0) ang = wrap32(-ang);
      return int'(dq(758 * ang));
   endfunction

   task automatic check(string name, longint actual, longint expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic fail_now(string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting for the DUT", name);
   endtask

   always @(negedge clock) begin : mon
      exp_t e;
      cycle++;
      if (!reset) begin
         expq.delete();
         m_iprev = 0;
         m_qprev = 0;
         check("reset_in_rd_en", bus.in_rd_en, 0);
         check("reset_out_wr_en", bus.out_wr_en, 0);
         check("reset_demod_out", bus.demod_out, 0);
      end else begin
         if (bus.out_full && expq.size() > 0) expq[0].stalled = 1'b1;
         if (bus.in_rd_en) begin
            check("rd_en_while_empty", bus.in_empty, 0);
            expq.push_back('{value: model(bus.Iin, bus.Qin, m_iprev, m_qprev),
                             pop_cycle: cycle, stalled: 1'b0});
            m_iprev = bus.Iin;
            m_qprev = bus.Qin;
            pop_count++;
         end
         if (bus.out_wr_en) begin
            check("wr_en_while_full", bus.out_full, 0);
            push_count++;
            last_push = bus.demod_out;
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_push: got push of %0d, expected no push", bus.demod_out);
            end else begin
               e = expq.pop_front();
               check("demod_out", bus.demod_out, e.value);
               if (!e.stalled) check("latency", cycle - e.pop_cycle, LAT);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pop_sample(int i, int q);
      int old;
      old = pop_count;
      bus.Iin = i;
      bus.Qin = q;
      bus.in_empty = 1'b0;
      for (int k = 0; k < 200 && pop_count == old; k++) tick();
      if (pop_count == old) fail_now("pop_timeout");
      bus.in_empty = 1'b1;
   endtask

   task automatic wait_push(int old);
      for (int k = 0; k < 200 && push_count == old; k++) tick();
      if (push_count == old) fail_now("push_timeout");
   endtask

   task automatic directed(string name, int i, int q, int expected);
      int old;
      old = push_count;
      pop_sample(i, q);
      wait_push(old);
      check(name, last_push, expected);
   endtask

   function automatic int rand_sample();
      case ($urandom_range(0, 7))
         0: return 0;
         1: return 1024;
         2: return -1024;
         3: return 16384;
         4: return -16384;
         default: return int'($urandom_range(0, 32768)) - 16384;
      endcase
   endfunction

   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int old;
      int target;
      int seen_pops;
      bus.Iin      = 0;
      bus.Qin      = 0;
      bus.in_empty = 1'b1;
      bus.out_full = 1'b0;
      reset        = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      repeat (2) tick();

      directed("first_sample", 1024, 0, 1190);
      directed("same_phase", 1024, 0, 1);
      directed("plus_quarter", 0, 1024, 1190);
      directed("second_quadrant", 0, -1024, 2379);
      directed("setup_prev", 1024, 0, 1190);
      directed("minus_quarter", 0, -1024, -1190);

      // Backpressure: previous is (0,-1024), so (1024,0) is +pi/2 -> 1190.
      bus.out_full = 1'b1;
      old = push_count;
      pop_sample(1024, 0);
      repeat (LAT + 3) tick();
      bus.Iin = 7;
      bus.Qin = 9;
      bus.in_empty = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("hold_out_wr_en", bus.out_wr_en, 0);
         check("hold_in_rd_en", bus.in_rd_en, 0);
         check("hold_demod_out", bus.demod_out, 1190);
      end
      check("hold_no_push", push_count, old);
      bus.in_empty = 1'b1;
      bus.out_full = 1'b0;
      wait_push(old);
      check("release_value", last_push, 1190);
      repeat (5) tick();
      check("single_push", push_count, old + 1);

      // Reset while the divider is busy.
      old = push_count;
      pop_sample(3000, -500);
      repeat (10) tick();
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      repeat (LAT + 10) tick();
      check("no_push_after_reset", push_count, old);
      directed("after_reset", 1024, 0, 1190);

      // Randomized traffic with a flickering input FIFO.
      target    = push_count + 40;
      seen_pops = pop_count;
      bus.Iin   = rand_sample();
      bus.Qin   = rand_sample();
      for (int c = 0; c < 40 * 80 && push_count < target; c++) begin
         bus.in_empty = $urandom_range(0, 1) == 1;
         tick();
         if (pop_count != seen_pops) begin
            seen_pops = pop_count;
            bus.Iin = rand_sample();
            bus.Qin = rand_sample();
         end
      end
      bus.in_empty = 1'b1;
      check("random_pushes", push_count, target);
      repeat (LAT + 10) tick();
      check("drained", expq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fm_demod.md
Name: fm_demod

Overview:
- Sits directly downstream of the complex channel FIR in the FM receive chain and consumes its decimated I/Q stream.
- For each sample it forms the conjugate product of the current and previous samples, then runs a quantized quadrant arctan on it. This yields the instantaneous phase difference.
- The phase difference is scaled by the demod gain and written as one signed sample per input to the output FIFO, which feeds the audio filters.
- Fixed-point format matches the FIR: Q10, so QUANTIZE(x) = x*1024.

Parameters:
- DATA_WIDTH, 32, width of I/Q inputs and of the demod output (two's complement).
- QUANT_BITS, 10, fractional bits; DEQUANT(x) = signed(x)/1024, truncated toward zero.
- GAIN, 758, demod gain in Q10 (QUAD_RATE/(2*pi*MAX_DEV)).
- QUAD1, 804, pi/4 in Q10; QUAD3 = 3*QUAD1 = 2412.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- Iin  in  DATA_WIDTH  I sample from the upstream FIFO; first-word-fall-through, valid while in_empty=0.
- Qin  in  DATA_WIDTH  Q sample, same timing as Iin.
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  pop strobe to the upstream FIFO.
- out_full  in  1  downstream FIFO full.
- out_wr_en  out  1  push strobe to the downstream FIFO.
- demod_out  out  DATA_WIDTH  demodulated sample; valid when out_wr_en=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; in_rd_en=0; out_wr_en=0; demod_out=0.
  - Iprev=Qprev=0; all datapath registers 0; the divider is aborted.
- IDLE:
  - in_rd_en = !in_empty (combinational).
  - When in_empty=0: latch Icur=Iin and Qcur=Qin at that edge, then go to MULT.
- MULT (1 cycle), full-width signed products, each DEQUANTed:
  - r = DEQUANT(Icur*Iprev) + DEQUANT(Qcur*Qprev).
  - i = DEQUANT(Qcur*Iprev) - DEQUANT(Icur*Qprev).
  - Register r and abs_y = |i| + 1; go to DIV_START.
- DIV_START (1 cycle): load the divider, then go to DIV_WAIT.
  - If r >= 0: numerator = (r - abs_y) << 10, denominator = r + abs_y.
  - If r < 0: numerator = (r + abs_y) << 10, denominator = abs_y - r.
- Divider properties:
  - Denominator is always >= 1, so no divide-by-zero path exists.
  - Quotient is signed and truncated toward zero.
  - Takes exactly DATA_WIDTH cycles from start to done.
- DIV_WAIT: hold until the divider's done pulse; latch q and go to ANGLE.
- ANGLE (1 cycle):
  - angle = QUAD1 - DEQUANT(QUAD1*q) if r >= 0; otherwise angle = QUAD3 - DEQUANT(QUAD1*q).
  - If i < 0, negate angle.
  - result = DEQUANT(GAIN*angle); go to WRITE.
- WRITE:
  - out_wr_en = !out_full (combinational); demod_out holds result.
  - When out_full=0: on that edge set Iprev=Icur, Qprev=Qcur and go to IDLE.
- Latency and throughput:
  - In-pop to out-push is DATA_WIDTH+5 cycles when neither FIFO stalls.
  - Exactly one output per input; at most one sample in flight.
- Backpressure: while out_full=1, stay in WRITE with in_rd_en=0, and hold demod_out and the previous-sample registers.
- Empty input: stay in IDLE with out_wr_en=0.
- Intermediate widths: products are 2*DATA_WIDTH before DEQUANT; r and i are truncated to DATA_WIDTH (no saturation).
- Reset mid-operation: any state returns to IDLE, previous-sample registers clear, and no partial output is pushed.
- First sample after reset uses Iprev=Qprev=0.

Decomposition:
- Package fm_demod_pkg holds:
  - state enum {IDLE, MULT, DIV_START, DIV_WAIT, ANGLE, WRITE};
  - QUANT_BITS, QUAD1, QUAD3 and GAIN constants;
  - a DEQUANT function (truncate toward zero).
- One sub-module, div_seq: radix-2 signed restoring divider.
  - Ports: clock, reset, start, dividend, divisor, quotient, done.
  - Latency DATA_WIDTH cycles; sign fixed up at the end.

Test Plan:
- After reset, push (I=1024,Q=0) -> one push with demod_out=1190 (r=0, i=0, q=-1024, angle=1608).
- Then push (1024,0) -> demod_out=1 (r=1024, q=1022, angle=2).
- Prev (1024,0), push (0,1024) -> demod_out=1190 (i=1024, abs_y=1025, angle=1608, i.e. +pi/2).
- Prev (0,1024), push (0,-1024) -> demod_out=2379 (r=-1024, q=-1022, angle=3214).
- Prev (1024,0), push (0,-1024) -> demod_out=-1190 (i<0, angle negated to -1608).
- Hold out_full=1 for 5 cycles in WRITE -> out_wr_en=0, in_rd_en=0, demod_out stable; a single push follows on release.
- Assert reset in DIV_WAIT -> no push. The next input (1024,0) then yields 1190, because the previous sample was cleared.
- Keep in_empty toggling randomly while checking against the C golden model.
  - Required: latency exactly DATA_WIDTH+5 cycles when no stall occurs.
